// File: rtl/cam_dvp_stream_gen.sv
// OV7670-style DVP transmitter: vsync/href/byte timing carrying
// deterministic RGB565 test patterns, two bytes per pixel.
module cam_dvp_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_tick,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    localparam int L   = 2 * H_ACTIVE + H_BLANK;
    localparam int BCW = $clog2(L);
    localparam int LCW = $clog2(V_ACTIVE + VSYNC_LINES + V_BACK + V_FRONT + 1);
    localparam logic [15:0] BAR_DIV = 16'(H_ACTIVE / 8);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    state_t         state, state_n;
    logic [BCW-1:0] bc, bc_n;
    logic [LCW-1:0] lc, lc_n;
    logic [LCW-1:0] n_lines;
    logic [1:0]     pat_q;
    logic [15:0]    solid_q;
    logic           start_n;
    logic           wrap_n;
    logic           last_bc;
    logic           last_ln;
    logic [15:0]    x16;
    logic [15:0]    bar;
    logic [15:0]    pix;
    logic           vsync_n;
    logic           href_n;
    logic [7:0]     data_n;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        unique case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    always_comb begin
        unique case (state)
            VSYNC:   n_lines = LCW'(VSYNC_LINES);
            VBACK:   n_lines = LCW'(V_BACK);
            ACTIVE:  n_lines = LCW'(V_ACTIVE);
            default: n_lines = LCW'(V_FRONT);
        endcase
    end

    assign last_bc = (bc == BCW'(L - 1));
    assign last_ln = (lc == n_lines - 1'b1);

    always_comb begin
        state_n = state;
        bc_n    = bc;
        lc_n    = lc;
        start_n = 1'b0;
        wrap_n  = 1'b0;
        if (state == IDLE) begin
            if (enable) begin
                state_n = VSYNC;
                start_n = 1'b1;
            end
        end else if (!last_bc) begin
            bc_n = bc + 1'b1;
        end else begin
            bc_n = '0;
            if (!last_ln) begin
                lc_n = lc + 1'b1;
            end else begin
                lc_n = '0;
                unique case (state)
                    VSYNC:  state_n = VBACK;
                    VBACK:  state_n = ACTIVE;
                    ACTIVE: state_n = VFRONT;
                    default: begin
                        wrap_n = 1'b1;
                        if (enable) begin
                            state_n = VSYNC;
                            start_n = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Pixel for the position the outputs will show after this tick.
    always_comb begin
        x16 = 16'(bc_n >> 1);
        bar = x16 / BAR_DIV;
        unique case (pat_q)
            2'd0:    pix = solid_q;
            2'd1:    pix = bar_color((bar > 16'd7) ? 3'd7 : bar[2:0]);
            2'd2:    pix = {x16[7:3], x16[7:2], x16[7:3]};
            default: pix = {8'(lc_n), x16[7:0]};
        endcase
    end

    assign vsync_n = (state_n == VSYNC);
    assign href_n  = (state_n == ACTIVE) && (bc_n < BCW'(2 * H_ACTIVE));
    assign data_n  = !href_n ? 8'h00 : (bc_n[0] ? pix[7:0] : pix[15:8]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bc          <= '0;
            lc          <= '0;
            pat_q       <= '0;
            solid_q     <= '0;
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_data    <= 8'h00;
            frame_start <= 1'b0;
            frame_count <= 8'h00;
        end else begin
            frame_start <= 1'b0;
            if (byte_tick) begin
                state       <= state_n;
                bc          <= bc_n;
                lc          <= lc_n;
                cam_vsync   <= vsync_n;
                cam_href    <= href_n;
                cam_data    <= data_n;
                frame_start <= start_n;
                if (start_n) begin
                    pat_q   <= pattern_sel;
                    solid_q <= solid_color;
                end
                if (wrap_n) begin
                    frame_count <= frame_count + 8'd1;
                end
            end
        end
    end

endmodule
